onehot_pulse_decoder: RTL and testbench

Sequential 3-to-8 decoder, the inverse of the priority encoder path. It accepts a queue of {index, length} commands over a valid/ready handshake and drives a registered one-hot output, `dec_out`. Each command raises `dec_out[idx]` for a programmed number of cycles, with a configurable idle gap between pulses. It is used to fan an encoded channel index back out to per-channel strobes/enables.

---
 rtl/onehot_dec_pkg.sv | 23 ++
 rtl/onehot_pulse_decoder_fifo.sv | 62 ++++++
 rtl/onehot_pulse_decoder.sv | 119 +++++++++++
 tb/tb_onehot_pulse_decoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_dec_pkg.sv
// Shared types and helpers for the one-hot pulse decoder.
package onehot_dec_pkg;

    localparam int N_OUT     = 8;
    localparam int IDX_W     = 3;
    localparam int CMD_LEN_W = 4;

    typedef struct packed {
        logic [IDX_W-1:0]     idx;
        logic [CMD_LEN_W-1:0] len;
    } dec_cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } dec_state_e;

    function automatic logic [N_OUT-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return N_OUT'(1) << idx;
    endfunction

endpackage

// File: rtl/onehot_pulse_decoder_fifo.sv
// Synchronous command FIFO; pushes are refused when full, pops ignored when empty.
module dec_cmd_fifo
    import onehot_dec_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  dec_cmd_t                 wdata,
    output dec_cmd_t                 rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    dec_cmd_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic            push_ok, pop_ok;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/onehot_pulse_decoder.sv
// Queued 3-to-8 pulse decoder: each {idx,len} command drives dec_out[idx] for len cycles.
//   state  | meaning
//   IDLE   | no pulse; pops the FIFO head when one is available
//   ACTIVE | dec_out holds the one-hot of the current command, cnt_q counts down
//   GAP    | forced zero cycles between pulses, gap_q counts down
module onehot_pulse_decoder
    import onehot_dec_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int LEN_W      = CMD_LEN_W,
    parameter int GAP_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_idx,
    input  logic [LEN_W-1:0]         in_len,
    output logic [7:0]               dec_out,
    output logic                     pulse_last,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 2);

    dec_state_e         state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [N_OUT-1:0]   dec_q, dec_d;
    logic               pop, load;
    logic               full, empty;
    dec_cmd_t           head, wcmd;

    assign in_ready = !rst && !full;
    assign wcmd     = '{idx: in_idx, len: in_len};

    dec_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .pop   (pop),
        .wdata (wcmd),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        dec_d   = dec_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                dec_d = '0;
                if (!empty) load = 1'b1;
            end
            ACTIVE: begin
                if (cnt_q <= LEN_W'(1)) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        dec_d   = '0;
                        gap_d   = GAP_W'(GAP_CYCLES);
                    end else if (!empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        dec_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            GAP: begin
                dec_d = '0;
                if (gap_q <= GAP_W'(1)) begin
                    if (!empty) load = 1'b1;
                    else        state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                dec_d   = '0;
            end
        endcase
        // A load overrides whatever the state above decided; zero length runs as one cycle.
        if (load) begin
            state_d = ACTIVE;
            cnt_d   = (head.len == '0) ? LEN_W'(1) : head.len;
            dec_d   = idx_to_onehot(head.idx);
        end
        pop = load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            dec_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            dec_q   <= dec_d;
        end
    end

    assign dec_out    = dec_q;
    assign pulse_last = (state_q == ACTIVE) && (cnt_q == LEN_W'(1));
    // Busy tracks outstanding work; a trailing gap with nothing queued does not count.
    assign busy       = (state_q == ACTIVE) || !empty;

endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Directed bench for onehot_pulse_decoder: one instance with a 1-cycle gap, one back-to-back.
module tb_onehot_pulse_decoder;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_ready, pulse_last, busy;
    logic [2:0] in_idx;
    logic [3:0] in_len;
    logic [7:0] dec_out;
    logic [2:0] fifo_level;

    logic       rst_z, in_valid_z, in_ready_z, pulse_last_z, busy_z;
    logic [2:0] in_idx_z;
    logic [3:0] in_len_z;
    logic [7:0] dec_out_z;
    logic [2:0] fifo_level_z;

    int n_checks = 0;
    int n_fail   = 0;

    onehot_pulse_decoder #(.DEPTH(4), .LEN_W(4), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_len(in_len), .dec_out(dec_out),
        .pulse_last(pulse_last), .busy(busy), .fifo_level(fifo_level)
    );

    onehot_pulse_decoder #(.DEPTH(4), .LEN_W(4), .GAP_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst_z), .in_valid(in_valid_z), .in_ready(in_ready_z),
        .in_idx(in_idx_z), .in_len(in_len_z), .dec_out(dec_out_z),
        .pulse_last(pulse_last_z), .busy(busy_z), .fifo_level(fifo_level_z)
    );

    int exp_idx[$];
    int exp_len[$];
    int rec_idx[$];
    int rec_len[$];
    logic [7:0] prev_dec = '0;
    logic       prev_last = 1'b0;
    int         run = 0;
    int         nz_cycles = 0;

    function automatic int onehot_idx(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Pulse monitor: records {idx, width} of every pulse that completes with pulse_last.
    always @(negedge clk) begin
        n_checks++;
        if ($onehot0(dec_out) !== 1'b1) begin
            n_fail++;
            $error("FAIL onehot0: observed %0h expected onehot0", dec_out);
        end
        n_checks++;
        if ((!pulse_last || dec_out != 8'h00) !== 1'b1) begin
            n_fail++;
            $error("FAIL last_implies_dec: observed dec_out %0h with pulse_last", dec_out);
        end
        n_checks++;
        if ($onehot0(dec_out_z) !== 1'b1) begin
            n_fail++;
            $error("FAIL onehot0_z: observed %0h expected onehot0", dec_out_z);
        end
        if (dec_out != 8'h00) begin
            nz_cycles++;
            run = (prev_dec == 8'h00 || prev_last || prev_dec != dec_out) ? 1 : run + 1;
            if (pulse_last) begin
                rec_idx.push_back(onehot_idx(dec_out));
                rec_len.push_back(run);
            end
        end
        prev_dec  = dec_out;
        prev_last = pulse_last;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int idx, input int len);
        in_valid = 1'b1;
        in_idx   = idx[2:0];
        in_len   = len[3:0];
        if (in_ready) begin
            exp_idx.push_back(idx);
            exp_len.push_back(len == 0 ? 1 : len);
        end
    endtask

    task automatic drain();
        int waits = 0;
        while ((busy || fifo_level != 3'd0) && waits < 400) begin
            step();
            waits++;
        end
        chk("drain_busy", busy, 1'b0);
        repeat (3) step();
    endtask

    task automatic compare_queues();
        int n;
        chk("pulse_count", rec_idx.size(), exp_idx.size());
        n = (rec_idx.size() < exp_idx.size()) ? rec_idx.size() : exp_idx.size();
        for (int i = 0; i < n; i++) begin
            chk("pulse_idx", rec_idx[i], exp_idx[i]);
            chk("pulse_len", rec_len[i], exp_len[i]);
        end
        exp_idx.delete(); exp_len.delete();
        rec_idx.delete(); rec_len.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int waits;
        int nz_before;
        int order_idx[3];
        order_idx[0] = 3; order_idx[1] = 6; order_idx[2] = 0;

        rst = 1'b1; in_valid = 1'b0; in_idx = '0; in_len = '0;
        rst_z = 1'b1; in_valid_z = 1'b0; in_idx_z = '0; in_len_z = '0;
        repeat (2) step();
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_dec", dec_out, 8'h00);
        chk("rst_last", pulse_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_level", fifo_level, 3'd0);
        chk("rst_ready_z", in_ready_z, 1'b0);
        rst = 1'b0; rst_z = 1'b0;
        step();
        chk("ready_after_rst", in_ready, 1'b1);

        // Single pulse idx=5 len=3
        offer(5, 3);
        step(); in_valid = 1'b0;
        chk("single_c1_dec", dec_out, 8'h00);
        step();
        chk("single_c2_dec", dec_out, 8'h20);
        chk("single_c2_last", pulse_last, 1'b0);
        step();
        chk("single_c3_dec", dec_out, 8'h20);
        chk("single_c3_last", pulse_last, 1'b0);
        step();
        chk("single_c4_dec", dec_out, 8'h20);
        chk("single_c4_last", pulse_last, 1'b1);
        step();
        chk("single_c5_dec", dec_out, 8'h00);
        chk("single_c5_busy", busy, 1'b0);
        step();

        // Zero length
        offer(0, 0);
        step(); in_valid = 1'b0;
        step();
        chk("zero_dec", dec_out, 8'h01);
        chk("zero_last", pulse_last, 1'b1);
        step();
        chk("zero_after_dec", dec_out, 8'h00);
        chk("zero_after_last", pulse_last, 1'b0);

        // Back-to-back on the zero-gap instance
        in_valid_z = 1'b1; in_idx_z = 3'd1; in_len_z = 4'd2;
        step();
        in_idx_z = 3'd7; in_len_z = 4'd1;
        step(); in_valid_z = 1'b0;
        chk("b2b_0_dec", dec_out_z, 8'h02);
        chk("b2b_0_last", pulse_last_z, 1'b0);
        step();
        chk("b2b_1_dec", dec_out_z, 8'h02);
        chk("b2b_1_last", pulse_last_z, 1'b1);
        step();
        chk("b2b_2_dec", dec_out_z, 8'h80);
        chk("b2b_2_last", pulse_last_z, 1'b1);
        step();
        chk("b2b_3_dec", dec_out_z, 8'h00);
        chk("b2b_3_last", pulse_last_z, 1'b0);
        chk("b2b_busy", busy_z, 1'b0);

        // Backpressure
        drain();
        offer(1, 15); step();
        offer(2, 1);  step();
        offer(3, 2);  step();
        offer(4, 3);  step();
        offer(5, 0);  step();
        chk("bp_level_full", fifo_level, 3'd4);
        chk("bp_ready_low", in_ready, 1'b0);
        chk("bp_dec", dec_out, 8'h02);
        offer(6, 1);
        waits = 0;
        while (!in_ready && waits < 40) begin
            step();
            waits++;
        end
        chk("bp_ready_return", waits, 13);
        chk("bp_level_after_pop", fifo_level, 3'd3);
        offer(6, 1);
        step(); in_valid = 1'b0;
        drain();
        compare_queues();

        // Reset mid-pulse
        offer(3, 4); step();
        offer(5, 2); step();
        offer(6, 2);
        chk("rstmid_first_dec", dec_out, 8'h08);
        step(); in_valid = 1'b0;
        chk("rstmid_second_dec", dec_out, 8'h08);
        rst = 1'b1;
        step();
        chk("rstmid_dec", dec_out, 8'h00);
        chk("rstmid_level", fifo_level, 3'd0);
        chk("rstmid_last", pulse_last, 1'b0);
        rst = 1'b0;
        exp_idx.delete(); exp_len.delete();
        rec_idx.delete(); rec_len.delete();
        nz_before = nz_cycles;
        repeat (20) step();
        chk("rstmid_no_pulses", nz_cycles, nz_before);
        chk("rstmid_no_records", rec_idx.size(), 0);
        chk("rstmid_busy", busy, 1'b0);

        // Ordering with random lengths
        for (int k = 0; k < 3; k++) begin
            offer(order_idx[k], int'($urandom_range(0, 15)));
            step();
        end
        in_valid = 1'b0;
        chk("order_accepted", exp_idx.size(), 3);
        drain();
        chk("order_first", (rec_idx.size() > 0) ? rec_idx[0] : -1, 3);
        compare_queues();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
